// File: rtl/serial_xor_arbiter.sv
// serial_xor_arbiter: two requesters share one bit-serial parity engine.
// A round-robin grant in IDLE picks one operand. SHIFT folds it one bit per cycle
// into a shared XOR accumulator. DONE presents the parity and the owner's index
// until the consumer takes it.
module serial_xor_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_data,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_data,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic         res_valid,
  output logic         res_parity,
  output logic         res_id,
  input  logic         res_ready,
  output logic         busy
);

  localparam int CntW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } stateType;

  stateType          state;
  stateType          nextState;
  logic [N-1:0]      shiftReg;
  logic              acc;
  logic [CntW-1:0]   bitCount;
  logic              grantId;
  logic              lastGrant;
  logic              pickReq1;
  logic              accept;
  logic              lastShift;

  // Round-robin choice: req1 wins if it is alone, or if both are waiting and req0 went last
  always_comb begin
    pickReq1   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    if (req1_valid && (!req0_valid || (lastGrant == 1'b0))) begin
      pickReq1 = 1'b1;
    end
    if ((state == IDLE) && !reset) begin
      req0_ready = req0_valid && !pickReq1;
      req1_ready = pickReq1;
    end
    accept = req0_ready || req1_ready;
  end

  // Next-state selection; SHIFT ends on the cycle that folds in the final bit
  always_comb begin
    nextState = state;
    lastShift = (bitCount == CntW'(N - 1));
    unique case (state)
      IDLE: begin
        if (accept) begin
          nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (lastShift) begin
          nextState = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State register and datapath: capture on accept, fold one bit per SHIFT cycle, retire in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shiftReg  <= '0;
      acc       <= 1'b0;
      bitCount  <= '0;
      grantId   <= 1'b0;
      lastGrant <= 1'b1;
    end else begin
      state <= nextState;
      unique case (state)
        IDLE: begin
          if (accept) begin
            shiftReg <= pickReq1 ? req1_data : req0_data;
            acc      <= 1'b0;
            bitCount <= '0;
            grantId  <= pickReq1;
          end
        end
        SHIFT: begin
          acc      <= acc ^ shiftReg[0];
          shiftReg <= shiftReg >> 1;
          bitCount <= bitCount + CntW'(1);
        end
        DONE: begin
          if (res_ready) begin
            lastGrant <= grantId;
          end
        end
        default: begin
          shiftReg <= '0;
        end
      endcase
    end
  end

  // Result outputs are gated so they read zero outside DONE
  always_comb begin
    res_valid  = (state == DONE);
    res_parity = (state == DONE) && acc;
    res_id     = (state == DONE) && grantId;
    busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_serial_xor_arbiter.sv
// tb_serial_xor_arbiter: directed checks of the shared parity engine with N=8,
// plus a second N=2 instance for back-to-back operands with the narrowest counter.
module tb_serial_xor_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid;
  logic       req1_valid;
  logic [7:0] req0_data;
  logic [7:0] req1_data;
  logic       req0_ready;
  logic       req1_ready;
  logic       res_valid;
  logic       res_parity;
  logic       res_id;
  logic       res_ready;
  logic       busy;

  logic       n2Req0Valid;
  logic       n2Req1Valid;
  logic [1:0] n2Req0Data;
  logic [1:0] n2Req1Data;
  logic       n2Req0Ready;
  logic       n2Req1Ready;
  logic       n2ResValid;
  logic       n2ResParity;
  logic       n2ResId;
  logic       n2ResReady;
  logic       n2Busy;

  int         testsRun = 0;
  int         testsFailed = 0;
  logic       sawValid;

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  serial_xor_arbiter #(.N(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_parity (res_parity),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  serial_xor_arbiter #(.N(2)) dutN2 (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (n2Req0Valid),
    .req0_data  (n2Req0Data),
    .req1_valid (n2Req1Valid),
    .req1_data  (n2Req1Data),
    .req0_ready (n2Req0Ready),
    .req1_ready (n2Req1Ready),
    .res_valid  (n2ResValid),
    .res_parity (n2ResParity),
    .res_id     (n2ResId),
    .res_ready  (n2ResReady),
    .busy       (n2Busy)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                               input logic v1, input logic [7:0] d1,
                               input logic rr);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    res_ready  = rr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  task automatic checkShiftCycles(input string tag, input int count);
    for (int i = 0; i < count; i++) begin
      tick();
      checkOutput({tag, "_res_valid"}, res_valid, 1'b0);
      checkOutput({tag, "_ready0"}, req0_ready, 1'b0);
      checkOutput({tag, "_ready1"}, req1_ready, 1'b0);
      checkOutput({tag, "_busy"}, busy, 1'b1);
    end
  endtask

  // Directed sequence covering reset, single request, ties, stalls, mid-shift reset and N=2
  initial begin
    reset       = 1'b1;
    n2Req0Valid = 1'b0;
    n2Req1Valid = 1'b0;
    n2Req0Data  = 2'b00;
    n2Req1Data  = 2'b00;
    n2ResReady  = 1'b1;
    applyStimulus(1'b1, 8'h3C, 1'b1, 8'hC3, 1'b0);
    tick();
    tick();
    checkOutput("rst_ready0", req0_ready, 1'b0);
    checkOutput("rst_ready1", req1_ready, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_res_valid", res_valid, 1'b0);
    checkOutput("rst_res_parity", res_parity, 1'b0);
    checkOutput("rst_res_id", res_id, 1'b0);

    // Single requester 0 with 8'hB5: result in cycle 9, parity 1, id 0
    reset = 1'b0;
    applyStimulus(1'b1, 8'hB5, 1'b0, 8'h00, 1'b1);
    checkOutput("b5_c0_ready0", req0_ready, 1'b1);
    checkOutput("b5_c0_ready1", req1_ready, 1'b0);
    checkOutput("b5_c0_busy", busy, 1'b0);
    tick();
    applyStimulus(1'b0, 8'hB5, 1'b0, 8'h00, 1'b1);
    checkOutput("b5_c1_busy", busy, 1'b1);
    checkOutput("b5_c1_res_valid", res_valid, 1'b0);
    checkShiftCycles("b5_shift", 7);
    tick();
    checkOutput("b5_c9_res_valid", res_valid, 1'b1);
    checkOutput("b5_c9_parity", res_parity, 1'b1);
    checkOutput("b5_c9_id", res_id, 1'b0);
    tick();
    checkOutput("b5_c10_res_valid", res_valid, 1'b0);
    checkOutput("b5_c10_busy", busy, 1'b0);

    // Tie after reset: req0 (FF, parity 0), then req1 (01, parity 1), then req0 again
    reset = 1'b1;
    applyStimulus(1'b1, 8'hFF, 1'b1, 8'h01, 1'b1);
    checkOutput("tie_rst_ready0", req0_ready, 1'b0);
    checkOutput("tie_rst_ready1", req1_ready, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("tie1_ready0", req0_ready, 1'b1);
    checkOutput("tie1_ready1", req1_ready, 1'b0);
    checkShiftCycles("tie1_shift", 8);
    tick();
    checkOutput("tie1_res_valid", res_valid, 1'b1);
    checkOutput("tie1_parity", res_parity, 1'b0);
    checkOutput("tie1_id", res_id, 1'b0);
    checkOutput("tie1_done_ready1", req1_ready, 1'b0);
    tick();
    checkOutput("tie2_ready1", req1_ready, 1'b1);
    checkOutput("tie2_ready0", req0_ready, 1'b0);
    checkOutput("tie2_res_valid", res_valid, 1'b0);
    checkShiftCycles("tie2_shift", 8);
    tick();
    checkOutput("tie2_res_valid_done", res_valid, 1'b1);
    checkOutput("tie2_parity", res_parity, 1'b1);
    checkOutput("tie2_id", res_id, 1'b1);
    tick();
    checkOutput("tie3_ready0", req0_ready, 1'b1);
    checkOutput("tie3_ready1", req1_ready, 1'b0);

    // Third operand (req0, FF) stalled in DONE for 5 cycles with both requesters waiting
    applyStimulus(1'b1, 8'hFF, 1'b1, 8'h01, 1'b0);
    checkShiftCycles("stall_shift", 8);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_res_valid", res_valid, 1'b1);
      checkOutput("stall_parity", res_parity, 1'b0);
      checkOutput("stall_id", res_id, 1'b0);
      checkOutput("stall_ready0", req0_ready, 1'b0);
      checkOutput("stall_ready1", req1_ready, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("stall_release_valid", res_valid, 1'b1);
    tick();
    checkOutput("stall_after_valid", res_valid, 1'b0);
    checkOutput("stall_after_parity", res_parity, 1'b0);
    checkOutput("stall_after_id", res_id, 1'b0);
    checkOutput("stall_after_busy", busy, 1'b0);

    // Reset during SHIFT cycle 3 discards req1's operand with no result
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h07, 1'b1);
    checkOutput("rsh_c0_ready1", req1_ready, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h07, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    #1;
    checkOutput("rsh_c3_busy", busy, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rsh_c4_busy", busy, 1'b0);
    checkOutput("rsh_c4_res_valid", res_valid, 1'b0);
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (res_valid !== 1'b0) sawValid = 1'b1;
    end
    checkOutput("rsh_no_result", sawValid, 1'b0);

    // Captured 8'h00 is kept even though req0_data changes to 8'hFF in cycle 1
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("cap_c0_ready0", req0_ready, 1'b1);
    tick();
    applyStimulus(1'b1, 8'hFF, 1'b0, 8'h00, 1'b1);
    checkOutput("cap_c1_ready0", req0_ready, 1'b0);
    checkShiftCycles("cap_shift", 7);
    tick();
    applyStimulus(1'b0, 8'hFF, 1'b0, 8'h00, 1'b1);
    checkOutput("cap_c9_res_valid", res_valid, 1'b1);
    checkOutput("cap_c9_parity", res_parity, 1'b0);
    checkOutput("cap_c9_id", res_id, 1'b0);
    tick();
    checkOutput("cap_c10_busy", busy, 1'b0);

    // N=2: 2'b11 gives parity 0 in cycle 3, then 2'b10 gives parity 1 in cycle 7
    n2Req0Valid = 1'b1;
    n2Req0Data  = 2'b11;
    n2ResReady  = 1'b1;
    #1;
    checkOutput("n2_c0_ready0", n2Req0Ready, 1'b1);
    tick();
    n2Req0Data = 2'b10;
    #1;
    checkOutput("n2_c1_busy", n2Busy, 1'b1);
    checkOutput("n2_c1_ready0", n2Req0Ready, 1'b0);
    tick();
    checkOutput("n2_c2_res_valid", n2ResValid, 1'b0);
    tick();
    checkOutput("n2_c3_res_valid", n2ResValid, 1'b1);
    checkOutput("n2_c3_parity", n2ResParity, 1'b0);
    checkOutput("n2_c3_ready0", n2Req0Ready, 1'b0);
    tick();
    checkOutput("n2_c4_ready0", n2Req0Ready, 1'b1);
    checkOutput("n2_c4_res_valid", n2ResValid, 1'b0);
    tick();
    n2Req0Valid = 1'b0;
    #1;
    tick();
    checkOutput("n2_c6_res_valid", n2ResValid, 1'b0);
    tick();
    checkOutput("n2_c7_res_valid", n2ResValid, 1'b1);
    checkOutput("n2_c7_parity", n2ResParity, 1'b1);
    checkOutput("n2_c7_id", n2ResId, 1'b0);
    tick();
    checkOutput("n2_c8_busy", n2Busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
